// File: rtl/matched_filter_stream.sv
// Streaming complex matched filter: loadable coefficient set, one time-multiplexed
// complex MAC per accepted sample, and a scaled, saturated magnitude output.
module matched_filter_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int TAPS        = 32,
    parameter int MAG_MODE    = 0,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          coeffLoad,
    input  logic                          coeffValid,
    input  logic signed [COEFF_WIDTH-1:0] coeffInRe,
    input  logic signed [COEFF_WIDTH-1:0] coeffInIm,
    output logic                          coeffSetFlag,
    input  logic                          dataValid,
    output logic                          dataReady,
    input  logic signed [DATA_WIDTH-1:0]  dataInRe,
    input  logic signed [DATA_WIDTH-1:0]  dataInIm,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [OUT_WIDTH-1:0]          outMag,
    output logic                          satFlag
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int MAG_W  = ACC_W + 1;
    localparam int SUM_W  = MAG_W + 1;
    localparam int PTR_W  = $clog2(TAPS);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TAPS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [SUM_W+OUT_WIDTH-1:0] OUT_MAX = {{SUM_W{1'b0}}, {OUT_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEFF,
        READY,
        MAC,
        MAG,
        OUTPUT
    } state_t;

    state_t state;

    logic signed [COEFF_WIDTH-1:0] coefRe [TAPS];
    logic signed [COEFF_WIDTH-1:0] coefIm [TAPS];
    logic signed [DATA_WIDTH-1:0]  lineRe [TAPS];
    logic signed [DATA_WIDTH-1:0]  lineIm [TAPS];

    logic [PTR_W-1:0] coefIdx;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] tapCnt;

    logic signed [PROD_W-1:0] termRe, termIm;
    logic signed [PROD_W-1:0] prodRe_p1, prodIm_p1;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  accRe, accIm;

    logic [SUM_W-1:0]   magSum;
    logic [OUT_WIDTH:0] magSat;

    logic dataAccept;
    logic coefWrite;
    logic loadDone;

    function automatic logic [PTR_W-1:0] wrapInc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_ONE;
    endfunction

    function automatic logic [PTR_W-1:0] wrapDec(input logic [PTR_W-1:0] p);
        return (p == '0) ? LAST_IDX : p - PTR_ONE;
    endfunction

    // One extra bit of headroom so the most negative accumulator value has a magnitude.
    function automatic logic [MAG_W-1:0] absVal(input logic signed [ACC_W-1:0] v);
        logic signed [MAG_W-1:0] e;
        e = MAG_W'(v);
        return e[MAG_W-1] ? $unsigned(-e) : $unsigned(e);
    endfunction

    function automatic logic [SUM_W-1:0] selectMag(input logic [MAG_W-1:0] a,
                                                   input logic [MAG_W-1:0] b);
        logic [SUM_W-1:0] ea, eb, hi, lo;
        ea = SUM_W'(a);
        eb = SUM_W'(b);
        if (MAG_MODE == 0) return ea + eb;
        hi = (ea >= eb) ? ea : eb;
        lo = (ea >= eb) ? eb : ea;
        return hi + (lo >> 1);
    endfunction

    // Returns {saturated, value}; widened compare keeps it valid for any OUT_WIDTH.
    function automatic logic [OUT_WIDTH:0] saturate(input logic [SUM_W-1:0] v);
        logic [SUM_W+OUT_WIDTH-1:0] wide;
        wide = {{OUT_WIDTH{1'b0}}, v};
        if (wide > OUT_MAX) return {1'b1, {OUT_WIDTH{1'b1}}};
        return {1'b0, wide[OUT_WIDTH-1:0]};
    endfunction

    assign dataReady  = (state == READY) && !coeffLoad;
    assign dataAccept = dataValid && dataReady;
    assign coefWrite  = (state == LOAD_COEFF) && coeffValid && !coeffLoad;
    assign loadDone   = coefWrite && (coefIdx == LAST_IDX);

    // Stage p0: complex product of the selected delay-line sample and coefficient.
    always_comb begin
        logic signed [PROD_W-1:0] xRe, xIm, hRe, hIm;
        xRe    = PROD_W'(lineRe[rdPtr]);
        xIm    = PROD_W'(lineIm[rdPtr]);
        hRe    = PROD_W'(coefRe[tapCnt]);
        hIm    = PROD_W'(coefIm[tapCnt]);
        termRe = xRe * hRe - xIm * hIm;
        termIm = xRe * hIm + xIm * hRe;
    end

    always_comb begin
        magSum = selectMag(absVal(accRe), absVal(accIm)) >> OUT_SHIFT;
        magSat = saturate(magSum);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            coeffSetFlag <= 1'b0;
            outValid     <= 1'b0;
            outMag       <= '0;
            satFlag      <= 1'b0;
            coefIdx      <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            tapCnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coeffLoad) begin
                        state        <= LOAD_COEFF;
                        coefIdx      <= '0;
                        coeffSetFlag <= 1'b0;
                    end
                end
                LOAD_COEFF: begin
                    if (coeffLoad) begin
                        coefIdx <= '0;
                    end else if (coeffValid) begin
                        if (coefIdx == LAST_IDX) begin
                            state        <= READY;
                            coeffSetFlag <= 1'b1;
                            wrPtr        <= '0;
                        end else begin
                            coefIdx <= coefIdx + PTR_ONE;
                        end
                    end
                end
                READY: begin
                    if (coeffLoad) begin
                        state        <= LOAD_COEFF;
                        coefIdx      <= '0;
                        coeffSetFlag <= 1'b0;
                    end else if (dataAccept) begin
                        state  <= MAC;
                        rdPtr  <= wrPtr;
                        wrPtr  <= wrapInc(wrPtr);
                        tapCnt <= '0;
                    end
                end
                MAC: begin
                    tapCnt <= wrapInc(tapCnt);
                    rdPtr  <= wrapDec(rdPtr);
                    if (tapCnt == LAST_IDX) state <= MAG;
                end
                MAG: begin
                    // Wait for the last product to drain into the accumulator.
                    if (!vld_p1) begin
                        outMag   <= magSat[OUT_WIDTH-1:0];
                        satFlag  <= magSat[OUT_WIDTH];
                        outValid <= 1'b1;
                        state    <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        state    <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: registered product feeds the accumulator one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            prodRe_p1 <= '0;
            prodIm_p1 <= '0;
            accRe     <= '0;
            accIm     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coefRe[i] <= '0;
                coefIm[i] <= '0;
                lineRe[i] <= '0;
                lineIm[i] <= '0;
            end
        end else begin
            vld_p1 <= (state == MAC);
            if (state == MAC) begin
                prodRe_p1 <= termRe;
                prodIm_p1 <= termIm;
            end
            if (coefWrite) begin
                coefRe[coefIdx] <= coeffInRe;
                coefIm[coefIdx] <= coeffInIm;
            end
            if (loadDone) begin
                for (int i = 0; i < TAPS; i++) begin
                    lineRe[i] <= '0;
                    lineIm[i] <= '0;
                end
            end
            if (dataAccept) begin
                lineRe[wrPtr] <= dataInRe;
                lineIm[wrPtr] <= dataInIm;
                accRe         <= '0;
                accIm         <= '0;
            end else if (vld_p1) begin
                accRe <= accRe + ACC_W'(prodRe_p1);
                accIm <= accIm + ACC_W'(prodIm_p1);
            end
        end
    end

endmodule
